// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - MIPS function codes and decode helpers for the HI/LO multiply/divide unit
package muldiv_unit_pkg;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == FUNC_DIV) || (f == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - conditional two's-complement negate; gives |x| when negate is the sign bit
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one result bit per cycle
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic [5:0]        func_code,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div_zero,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc_hi, acc_lo, opnd_b;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              op_div, neg_res, neg_rem, dz_pend, div_zero_q;

  logic              op_signed, accept, rt_zero, dz_accept, idle_write;
  logic [DATA_W-1:0] rs_abs, rt_abs;

  assign op_signed  = is_signed_op(func_code);
  assign accept     = i_start && (state == S_IDLE) && !i_flush && is_muldiv(func_code);
  assign rt_zero    = (i_rt_data == '0);
  assign dz_accept  = is_div_op(func_code) && rt_zero;
  assign idle_write = i_start && (state == S_IDLE) && !i_flush;

  muldiv_sign_fix #(.W(DATA_W)) u_rs_abs (
    .value(i_rs_data), .negate(op_signed & i_rs_data[DATA_W-1]), .result(rs_abs));
  muldiv_sign_fix #(.W(DATA_W)) u_rt_abs (
    .value(i_rt_data), .negate(op_signed & i_rt_data[DATA_W-1]), .result(rt_abs));

  // Multiply: {acc_hi,acc_lo} is the product/multiplier shift register.
  logic [DATA_W:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, {DATA_W{acc_lo[0]}} & opnd_b};

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [DATA_W:0] trial;
  assign trial = {acc_hi, acc_lo[DATA_W-1]} - {1'b0, opnd_b};

  logic [2*DATA_W-1:0] prod_fixed;
  logic [DATA_W-1:0]   quot_fixed, rem_fixed;

  muldiv_sign_fix #(.W(2*DATA_W)) u_prod_fix (
    .value({acc_hi, acc_lo}), .negate(neg_res), .result(prod_fixed));
  muldiv_sign_fix #(.W(DATA_W)) u_quot_fix (
    .value(acc_lo), .negate(neg_res), .result(quot_fixed));
  muldiv_sign_fix #(.W(DATA_W)) u_rem_fix (
    .value(acc_hi), .negate(neg_rem), .result(rem_fixed));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_next = dz_accept ? S_FIX : S_CALC;
        S_CALC:  if (cnt == CNT_W'(DATA_W - 1)) state_next = S_FIX;
        S_FIX:   state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = (state != S_IDLE);
    o_done = (state == S_FIX) && !i_flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd_b     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      op_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dz_pend    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt        <= '0;
            op_div     <= is_div_op(func_code);
            // On divide-by-zero acc_hi carries raw rs straight through to HI.
            acc_hi     <= dz_accept ? i_rs_data : '0;
            acc_lo     <= rs_abs;
            opnd_b     <= rt_abs;
            neg_res    <= op_signed & (i_rs_data[DATA_W-1] ^ i_rt_data[DATA_W-1]);
            neg_rem    <= op_signed & i_rs_data[DATA_W-1];
            dz_pend    <= dz_accept;
            div_zero_q <= 1'b0;
          end else if (idle_write && func_code == FUNC_MTHI) begin
            hi_q <= i_rs_data;
          end else if (idle_write && func_code == FUNC_MTLO) begin
            lo_q <= i_rs_data;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_div) begin
            if (!trial[DATA_W]) begin
              acc_hi <= trial[DATA_W-1:0];
              acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
            end else begin
              acc_hi <= {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
              acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[DATA_W:1];
            acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
          end
        end
        S_FIX: begin
          if (!i_flush) begin
            if (dz_pend) begin
              lo_q       <= '1;
              hi_q       <= acc_hi;
              div_zero_q <= 1'b1;
            end else if (op_div) begin
              lo_q <= quot_fixed;
              hi_q <= rem_fixed;
            end else begin
              {hi_q, lo_q} <= prod_fixed;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_flush;
  logic [5:0]  func_code;
  logic [31:0] i_rs_data, i_rt_data;
  logic        o_busy, o_done, o_div_zero;
  logic [31:0] o_hi, o_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_flush(i_flush),
    .func_code(func_code), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero),
    .o_hi(o_hi), .o_lo(o_lo));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, then count busy cycles; optionally poke a stray start at busy cycle poke_at.
  task automatic run_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input int poke_at, output int nbusy, output int done_at);
    @(negedge clk);
    func_code = f; i_rs_data = rs; i_rt_data = rt; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    nbusy = 0; done_at = 0;
    for (int k = 0; k < 100 && o_busy; k++) begin
      nbusy++;
      if (o_done) done_at = nbusy;
      if (nbusy == poke_at) begin
        i_start = 1'b1; func_code = FUNC_DIVU; i_rs_data = 32'd100; i_rt_data = 32'd7;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    check("busy_bounded", {63'd0, o_busy}, 64'd0);
  endtask

  int nb, da;
  logic seen_done;

  initial begin
    reset = 1'b1; i_start = 1'b0; i_flush = 1'b0;
    func_code = 6'h0; i_rs_data = '0; i_rt_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_dz",   {63'd0, o_div_zero}, 64'd0);
    check("rst_hilo", {o_hi, o_lo}, 64'd0);
    reset = 1'b0;

    run_op(FUNC_MULT, 32'hFFFFFFFD, 32'd7, 0, nb, da);
    check("mult_busy", 64'(nb), 64'd33);
    check("mult_done_at", 64'(da), 64'd33);
    check("mult_hilo", {o_hi, o_lo}, 64'hFFFFFFFF_FFFFFFEB);

    run_op(FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, nb, da);
    check("multu_hilo", {o_hi, o_lo}, 64'hFFFFFFFE_00000001);

    run_op(FUNC_DIV, 32'hFFFFFFF9, 32'd2, 0, nb, da);
    check("div_busy", 64'(nb), 64'd33);
    check("div_hilo", {o_hi, o_lo}, 64'hFFFFFFFF_FFFFFFFD);

    run_op(FUNC_DIVU, 32'd7, 32'd2, 0, nb, da);
    check("divu_hilo", {o_hi, o_lo}, 64'h00000001_00000003);

    run_op(FUNC_DIV, 32'd5, 32'd0, 0, nb, da);
    check("dz_busy", 64'(nb), 64'd1);
    check("dz_done_at", 64'(da), 64'd1);
    check("dz_hilo", {o_hi, o_lo}, 64'h00000005_FFFFFFFF);
    check("dz_flag", {63'd0, o_div_zero}, 64'd1);

    run_op(FUNC_DIVU, 32'd100, 32'd7, 0, nb, da);
    check("dz_cleared", {63'd0, o_div_zero}, 64'd0);
    check("divu2_hilo", {o_hi, o_lo}, 64'h00000002_0000000E);

    run_op(FUNC_DIV, 32'h80000000, 32'hFFFFFFFF, 0, nb, da);
    check("ovf_hilo", {o_hi, o_lo}, 64'h00000000_80000000);

    @(negedge clk);
    func_code = FUNC_MTHI; i_rs_data = 32'h1234; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("mthi_hi", {32'd0, o_hi}, 64'h1234);
    check("mthi_busy", {63'd0, o_busy}, 64'd0);
    func_code = FUNC_MTLO; i_rs_data = 32'hABCD; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("mtlo_lo", {32'd0, o_lo}, 64'hABCD);
    check("mtlo_busy", {63'd0, o_busy}, 64'd0);

    // DIV squashed by a flush on its 10th busy cycle
    func_code = FUNC_DIV; i_rs_data = 32'd100; i_rt_data = 32'd3; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k < 10; k++) begin
      seen_done |= o_done;
      @(negedge clk);
    end
    check("flush_busy_before", {63'd0, o_busy}, 64'd1);
    i_flush = 1'b1;
    #1 seen_done |= o_done;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush_idle", {63'd0, o_busy}, 64'd0);
    check("flush_no_done", {63'd0, seen_done}, 64'd0);
    check("flush_hilo", {o_hi, o_lo}, 64'h00001234_0000ABCD);

    func_code = FUNC_MULT; i_rs_data = 32'd9; i_rt_data = 32'd9; i_start = 1'b1; i_flush = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_flush = 1'b0;
    check("flush_start_busy", {63'd0, o_busy}, 64'd0);
    check("flush_start_hilo", {o_hi, o_lo}, 64'h00001234_0000ABCD);

    func_code = 6'h20; i_rs_data = 32'h55; i_rt_data = 32'h3; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("bad_func_busy", {63'd0, o_busy}, 64'd0);
    check("bad_func_hilo", {o_hi, o_lo}, 64'h00001234_0000ABCD);

    run_op(FUNC_MULTU, 32'd2, 32'd3, 5, nb, da);
    check("restart_busy", 64'(nb), 64'd33);
    check("restart_hilo", {o_hi, o_lo}, 64'h00000000_00000006);

    // Async reset in the middle of CALC
    func_code = FUNC_MULTU; i_rs_data = 32'd11; i_rt_data = 32'd13; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, o_busy}, 64'd0);
    check("arst_hilo", {o_hi, o_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(FUNC_MULT, 32'd6, 32'hFFFFFFFE, 0, nb, da);
    check("post_rst_hilo", {o_hi, o_lo}, 64'hFFFFFFFF_FFFFFFF4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
